// File: rtl/laser_fire_ctrl.sv
// laser_fire_ctrl
//   Turns raw trigger/reload pushbuttons into a single-cycle active-low fire
//   request for the laser driver. Enforces a magazine and a post-shot
//   lockout, and runs a timed reload sequence.
//
// Ports
//   clock        system clock
//   reset        synchronous, active-high reset
//   trigger_btn  raw trigger button (asynchronous, 1 = pressed)
//   reload_btn   raw reload button (asynchronous, 1 = pressed)
//   fire_n       active-low fire request, low for one cycle per shot
//   ammo         rounds remaining
//   reloading    high while reloading
//   busy         high whenever the controller is not idle
//   dry_fire     one-cycle pulse on a trigger press with an empty magazine

// Per-button synchroniser + debouncer. press is high for one cycle, the
// cycle after the debounced level rises.
module laser_fire_ctrl_debounce #(
   parameter int unsigned CYCLES = 500000
) (
   input  logic clock,
   input  logic reset,
   input  logic btn,
   output logic press
);
   localparam logic [31:0] LAST = 32'(CYCLES - 1);

   logic        s1;
   logic        s2;
   logic        level;
   logic        level_q;
   logic [31:0] cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         s1      <= 1'b0;
         s2      <= 1'b0;
         level   <= 1'b0;
         level_q <= 1'b0;
         cnt     <= '0;
      end else begin
         s1      <= btn;
         s2      <= s1;
         level_q <= level;
         if (s2 == level) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            level <= s2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 32'd1;
         end
      end
   end

   assign press = level & ~level_q;
endmodule

// state   | meaning
// IDLE    | ready; accepts trigger and reload presses
// LOCKOUT | shot just fired; driver is mid-cycle, all presses dropped
// RELOAD  | reload timer running; magazine refills on expiry
module laser_fire_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned LOCKOUT_CYCLES  = 200000000,
   parameter int unsigned RELOAD_CYCLES   = 150000000,
   parameter int unsigned MAX_AMMO        = 6
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       trigger_btn,
   input  logic       reload_btn,
   output logic       fire_n,
   output logic [3:0] ammo,
   output logic       reloading,
   output logic       busy,
   output logic       dry_fire
);
   typedef enum logic [1:0] {IDLE, LOCKOUT, RELOAD} state_t;

   localparam logic [3:0]  FULL        = 4'(MAX_AMMO);
   localparam logic [31:0] LOCKOUT_END = 32'(LOCKOUT_CYCLES - 1);
   localparam logic [31:0] RELOAD_END  = 32'(RELOAD_CYCLES - 1);

   logic        trig_press;
   logic        rel_press;
   state_t      state_q;
   state_t      state_d;
   logic [31:0] timer_q;
   logic [31:0] timer_d;
   logic [3:0]  ammo_d;
   logic        fire_n_d;
   logic        dry_fire_d;

   laser_fire_ctrl_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_trig_db (
      .clock (clock),
      .reset (reset),
      .btn   (trigger_btn),
      .press (trig_press)
   );

   laser_fire_ctrl_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_rel_db (
      .clock (clock),
      .reset (reset),
      .btn   (reload_btn),
      .press (rel_press)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         timer_q   <= '0;
         ammo      <= FULL;
         fire_n    <= 1'b1;
         dry_fire  <= 1'b0;
         reloading <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         ammo      <= ammo_d;
         fire_n    <= fire_n_d;
         dry_fire  <= dry_fire_d;
         reloading <= (state_d == RELOAD);
         busy      <= (state_d != IDLE);
      end
   end

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      ammo_d     = ammo;
      fire_n_d   = 1'b1;
      dry_fire_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (trig_press && (ammo != 4'd0)) begin
               // A shot takes priority; a simultaneous reload press is dropped.
               fire_n_d = 1'b0;
               ammo_d   = ammo - 4'd1;
               state_d  = LOCKOUT;
               timer_d  = '0;
            end else begin
               // Empty magazine: dry fire and a reload may start together.
               if (trig_press) begin
                  dry_fire_d = 1'b1;
               end
               if (rel_press && (ammo != FULL)) begin
                  state_d = RELOAD;
                  timer_d = '0;
               end
            end
         end
         LOCKOUT: begin
            if (timer_q == LOCKOUT_END) begin
               state_d = IDLE;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         RELOAD: begin
            if (timer_q == RELOAD_END) begin
               ammo_d  = FULL;
               state_d = IDLE;
               timer_d = '0;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         default: begin
            state_d = IDLE;
            timer_d = '0;
         end
      endcase
   end
endmodule

// File: tb/tb_laser_fire_ctrl.sv
module tb_laser_fire_ctrl;
   localparam int DB = 4;
   localparam int LAT = 2 + DB + 1;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       trigger_btn = 1'b0;
   logic       reload_btn = 1'b0;
   logic       fire_n;
   logic [3:0] ammo;
   logic       reloading;
   logic       busy;
   logic       dry_fire;

   typedef struct {
      int kind;   // 0 = fire_n pulse, 1 = dry_fire pulse
      int cyc;
      int ammo;
   } ev_t;

   ev_t exp_q[$];
   int  cyc = 0;
   int  checks = 0;
   int  errors = 0;

   laser_fire_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .LOCKOUT_CYCLES  (20),
      .RELOAD_CYCLES   (30),
      .MAX_AMMO        (3)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .trigger_btn (trigger_btn),
      .reload_btn  (reload_btn),
      .fire_n      (fire_n),
      .ammo        (ammo),
      .reloading   (reloading),
      .busy        (busy),
      .dry_fire    (dry_fire)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #300000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // Advance one cycle, then match any pulse the DUT produced against the
   // oldest expected event.
   task automatic step();
      ev_t e;
      int  kind;
      @(posedge clock);
      #1;
      if (reset === 1'b0 && (fire_n !== 1'b1 || dry_fire !== 1'b0)) begin
         kind = (fire_n !== 1'b1 && dry_fire !== 1'b0) ? 2 : ((fire_n !== 1'b1) ? 0 : 1);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: kind %0d at cycle %0d ammo %0d, required no pulse", kind, cyc, ammo);
         end else begin
            e = exp_q.pop_front();
            if (kind != e.kind || cyc != e.cyc || int'(ammo) != e.ammo) begin
               errors++;
               $display("FAIL pulse: got kind %0d cycle %0d ammo %0d, required kind %0d cycle %0d ammo %0d",
                        kind, cyc, ammo, e.kind, e.cyc, e.ammo);
            end
         end
      end
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Press the trigger for 4 cycles (just long enough to debounce) and
   // expect a shot LAT cycles later; returns once the lockout has ended.
   task automatic fire_shot(input int ammo_after);
      exp_q.push_back('{0, cyc + LAT, ammo_after});
      trigger_btn = 1'b1;
      steps(4);
      trigger_btn = 1'b0;
      steps(26);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      steps(2);
      checks++; if (fire_n !== 1'b1)    begin errors++; $display("FAIL reset_fire_n: got %b, required 1", fire_n); end
      checks++; if (ammo !== 4'd3)      begin errors++; $display("FAIL reset_ammo: got %0d, required 3", ammo); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
      checks++; if (reloading !== 1'b0) begin errors++; $display("FAIL reset_reloading: got %b, required 0", reloading); end
      checks++; if (dry_fire !== 1'b0)  begin errors++; $display("FAIL reset_dry_fire: got %b, required 0", dry_fire); end
      reset = 1'b0;
      steps(2);
   endtask

   task automatic test_single_shot();
      int busy_cnt = 0;
      exp_q.push_back('{0, cyc + LAT, 2});
      trigger_btn = 1'b1;
      for (int i = 1; i <= 45; i++) begin
         step();
         if (i == 10) trigger_btn = 1'b0;
         if (busy === 1'b1) busy_cnt++;
      end
      checks++; if (busy_cnt != 20) begin errors++; $display("FAIL single_busy_len: got %0d, required 20", busy_cnt); end
      checks++; if (ammo !== 4'd2)  begin errors++; $display("FAIL single_ammo: got %0d, required 2", ammo); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_missing: %0d pulses not seen, required 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_lockout_discard();
      exp_q.push_back('{0, cyc + LAT, 1});
      trigger_btn = 1'b1;
      for (int i = 1; i <= 45; i++) begin
         step();
         if (i == 4)  trigger_btn = 1'b0;
         if (i == 12) trigger_btn = 1'b1;   // five cycles into the lockout
         if (i == 18) trigger_btn = 1'b0;
      end
      checks++; if (ammo !== 4'd1) begin errors++; $display("FAIL lockout_ammo: got %0d, required 1", ammo); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL lockout_missing: %0d pulses not seen, required 0", exp_q.size()); exp_q.delete(); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_glitch();
      for (int g = 0; g < 20; g++) begin
         trigger_btn = 1'b1;
         steps(int'($urandom_range(1, 3)));
         trigger_btn = 1'b0;
         steps(int'($urandom_range(2, 4)));
      end
      steps(10);
      checks++; if (ammo !== 4'd3) begin errors++; $display("FAIL glitch_ammo: got %0d, required 3", ammo); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy: got %b, required 0", busy); end
   endtask

   task automatic test_magazine();
      fire_shot(2);
      fire_shot(1);
      fire_shot(0);
      exp_q.push_back('{1, cyc + LAT, 0});
      trigger_btn = 1'b1;
      steps(4);
      trigger_btn = 1'b0;
      steps(10);
      checks++; if (ammo !== 4'd0) begin errors++; $display("FAIL mag_ammo: got %0d, required 0", ammo); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mag_busy: got %b, required 0", busy); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL mag_missing: %0d pulses not seen, required 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_reload();
      int rl_cnt = 0;
      reload_btn = 1'b1;
      for (int i = 1; i <= 45; i++) begin
         step();
         if (i == 4)  reload_btn = 1'b0;
         if (i == 15) trigger_btn = 1'b1;
         if (i == 19) trigger_btn = 1'b0;
         if (reloading === 1'b1) rl_cnt++;
         if (i == 6) begin
            checks++; if (reloading !== 1'b0) begin errors++; $display("FAIL reload_early: got %b at step 6, required 0", reloading); end
         end
         if (i == 20) begin
            checks++; if (ammo !== 4'd0) begin errors++; $display("FAIL reload_mid_ammo: got %0d, required 0", ammo); end
         end
      end
      checks++; if (rl_cnt != 30)  begin errors++; $display("FAIL reload_len: got %0d, required 30", rl_cnt); end
      checks++; if (ammo !== 4'd3) begin errors++; $display("FAIL reload_ammo: got %0d, required 3", ammo); end
      rl_cnt = 0;
      reload_btn = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         step();
         if (i == 4) reload_btn = 1'b0;
         if (reloading !== 1'b0 || busy !== 1'b0) rl_cnt++;
      end
      checks++; if (rl_cnt != 0) begin errors++; $display("FAIL reload_full: busy/reloading high for %0d cycles, required 0", rl_cnt); end
   endtask

   task automatic test_reset_mid_reload();
      fire_shot(2);
      reload_btn = 1'b1;
      steps(4);
      reload_btn = 1'b0;
      steps(11);
      checks++; if (reloading !== 1'b1) begin errors++; $display("FAIL rst_reload_pre: got %b, required 1", reloading); end
      reset = 1'b1;
      step();
      checks++; if (reloading !== 1'b0) begin errors++; $display("FAIL rst_reload_rl: got %b, required 0", reloading); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_reload_busy: got %b, required 0", busy); end
      checks++; if (ammo !== 4'd3)      begin errors++; $display("FAIL rst_reload_ammo: got %0d, required 3", ammo); end
      reset = 1'b0;
      steps(5);
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rst_reload_missing: %0d pulses not seen, required 0", exp_q.size()); exp_q.delete(); end
   endtask

   task automatic test_simultaneous();
      fire_shot(2);
      exp_q.push_back('{0, cyc + LAT, 1});
      trigger_btn = 1'b1;
      reload_btn  = 1'b1;
      steps(4);
      trigger_btn = 1'b0;
      reload_btn  = 1'b0;
      steps(4);
      checks++; if (busy !== 1'b1 || reloading !== 1'b0) begin errors++; $display("FAIL simul_shot_state: busy %b reloading %b, required 1 0", busy, reloading); end
      steps(32);
      checks++; if (ammo !== 4'd1 || reloading !== 1'b0) begin errors++; $display("FAIL simul_shot_after: ammo %0d reloading %b, required 1 0", ammo, reloading); end
      fire_shot(0);
      exp_q.push_back('{1, cyc + LAT, 0});
      trigger_btn = 1'b1;
      reload_btn  = 1'b1;
      steps(4);
      trigger_btn = 1'b0;
      reload_btn  = 1'b0;
      steps(3);
      checks++; if (reloading !== 1'b1) begin errors++; $display("FAIL simul_dry_reload: got %b, required 1", reloading); end
      steps(40);
      checks++; if (ammo !== 4'd3 || busy !== 1'b0) begin errors++; $display("FAIL simul_refill: ammo %0d busy %b, required 3 0", ammo, busy); end
      checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL simul_missing: %0d pulses not seen, required 0", exp_q.size()); exp_q.delete(); end
   endtask

   initial begin
      test_reset();
      test_single_shot();
      test_lockout_discard();
      test_glitch();
      test_magazine();
      test_reload();
      test_reset_mid_reload();
      test_simultaneous();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/laser_fire_ctrl.md
Name: laser_fire_ctrl

Overview:
- Upstream stage of the laser driver: turns the raw player trigger and reload pushbuttons into the single-cycle active-low fire request the laser driver consumes on its `in` input.
- Synchronises and debounces both buttons.
- Enforces a magazine (ammo count) and a post-shot lockout that matches the driver's 2 s on / 2 s off cycle, so no request arrives while the driver is mid-cycle.
- Runs a timed reload sequence.

Parameters:
- DEBOUNCE_CYCLES, 500000, stable-level cycles required before a button change is accepted (10 ms at 50 MHz).
- LOCKOUT_CYCLES, 200000000, cycles after a shot during which firing is blocked (4 s at 50 MHz, equal to the driver's full on+off cycle).
- RELOAD_CYCLES, 150000000, reload duration in cycles (3 s).
- MAX_AMMO, 6, magazine size; legal range 1..15.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- trigger_btn  in  1  raw trigger button, asynchronous, 1 = pressed.
- reload_btn  in  1  raw reload button, asynchronous, 1 = pressed.
- fire_n  out  1  active-low fire request to the laser driver `in`; low for exactly 1 cycle per shot.
- ammo  out  4  rounds remaining.
- reloading  out  1  high while in RELOAD.
- busy  out  1  high when state != IDLE.
- dry_fire  out  1  1-cycle high pulse when the trigger is pressed with an empty magazine.

Behaviour:
- One clock only. Reset is synchronous, active-high, and has priority over everything in the same cycle.
- Reset values:
  - fire_n=1, ammo=MAX_AMMO, reloading=0, busy=0, dry_fire=0.
  - State IDLE.
  - All counters 0.
  - Synchroniser flops and debounced levels 0.
- Reset mid-lockout or mid-reload: IDLE with a full magazine on the next cycle.
- Synchroniser: each button passes through 2 flops.
- Debounce (per button, 32-bit counter):
  - If the synchronised level equals the debounced level, the counter clears.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the levels still differ, the debounced level flips and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never changes the debounced level.
- Press event: rising edge of the debounced level, 1 cycle wide. Releases generate no event.
- All outputs are registered. An action taken on a press event appears on the outputs in the following cycle.
- FSM states: IDLE, LOCKOUT, RELOAD.
- IDLE:
  - Trigger press and ammo>0:
    - fire_n=0 for 1 cycle.
    - ammo decrements by 1.
    - Go to LOCKOUT; timer=0.
  - Trigger press and ammo==0: dry_fire=1 for 1 cycle; stay in IDLE.
  - Reload press and ammo<MAX_AMMO: go to RELOAD; timer=0.
  - Reload press and ammo==MAX_AMMO: ignored.
  - Simultaneous trigger and reload presses:
    - ammo>0: the shot wins and the reload press is discarded.
    - ammo==0: dry_fire pulses and the reload starts in the same cycle.
- LOCKOUT:
  - The timer increments each cycle.
  - When timer==LOCKOUT_CYCLES-1, go to IDLE.
  - All presses are discarded (not queued), and there is no dry_fire.
- RELOAD:
  - reloading=1 and the timer increments.
  - When timer==RELOAD_CYCLES-1: ammo=MAX_AMMO and go to IDLE.
  - Trigger presses are discarded with no dry_fire.
  - Reload presses are ignored.
- fire_n is never low on two consecutive cycles. Consecutive fire_n pulses are at least LOCKOUT_CYCLES+1 cycles apart.
- ammo never underflows and never exceeds MAX_AMMO.
- Latency: a clean press stable from cycle 0 produces fire_n low at cycle 2 + DEBOUNCE_CYCLES + 1, ±1 cycle for sampling phase. The bench checks exact timing against its own debounce model.

Test Plan (DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=20, RELOAD_CYCLES=30, MAX_AMMO=3):
1. Reset → fire_n=1, ammo=3, busy=0, reloading=0, dry_fire=0. Reset asserted mid-RELOAD → IDLE and ammo=3 the next cycle.
2. trigger_btn held 10 cycles → exactly one fire_n low cycle, ammo=2, busy=1 for 20 cycles then 0. A second press 5 cycles into LOCKOUT → no fire_n, ammo stays 2.
3. trigger_btn glitches of 1–3 cycles separated by ≥2 low cycles, repeated 20 times → fire_n stays 1, ammo stays 3.
4. Three spaced presses (after each lockout ends) → ammo 3→2→1→0. Fourth press → dry_fire for 1 cycle, fire_n stays 1, ammo=0.
5. With ammo=0, press reload → reloading=1 for 30 cycles, then ammo=3. A trigger press during the reload → no fire_n, no dry_fire. Reload press with ammo=3 → reloading stays 0.
6. Simultaneous debounced trigger+reload presses:
   - ammo=2 → fire_n pulse, ammo=1, state LOCKOUT.
   - ammo=0 → dry_fire pulse and reloading=1 next cycle.
